decoder_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one decoded select bus among up to 64 requesters.

---
 rtl/decoder_rr_arbiter_pkg.sv | 12 +
 rtl/decoder_rr_arbiter_if.sv | 25 ++
 rtl/decoder_rr_arbiter_decoder6_64.sv | 35 +++
 rtl/decoder_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin grant arbiter and its decoder.
package decoder_pkg;

  localparam int IDX_W   = 6;
  localparam int MAX_REQ = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesting masters (master) and the arbiter (slave).
interface decoder_rr_arbiter_if
  import decoder_pkg::*;
#(
  parameter int N_REQ = 64
) ();

  logic [N_REQ-1:0]   req;
  logic               done;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [MAX_REQ-1:0] gnt_onehot;
  logic               gnt_timeout;

  modport master (
    output req, done,
    input  gnt_valid, gnt_idx, gnt_onehot, gnt_timeout
  );

  modport slave (
    input  req, done,
    output gnt_valid, gnt_idx, gnt_onehot, gnt_timeout
  );

endinterface

// File: rtl/decoder_rr_arbiter_decoder6_64.sv
// 6-to-64 one-hot decoder built from a tree of 3-to-8 decoders.
module decoder3_8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);

  // single-level decode, all zero when disabled
  assign y = en ? (8'b0000_0001 << a) : 8'b0000_0000;

endmodule

module decoder6_64 (
  input  logic        en,
  input  logic [5:0]  a,
  output logic [63:0] y
);

  logic [7:0] grp_en;

  decoder3_8 u_hi (
    .en (en),
    .a  (a[5:3]),
    .y  (grp_en)
  );

  for (genvar g = 0; g < 8; g++) begin : g_lo
    decoder3_8 u_lo (
      .en (grp_en[g]),
      .a  (a[2:0]),
      .y  (y[g*8 +: 8])
    );
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter: grants one of N_REQ requesters, holds the grant until
// done or withdrawal, then moves priority to the next index.
// Optional grant watchdog enabled by defining GRANT_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no grant; scanning req circularly from ptr
// ST_GRANT | gnt_idx owns the resource until done, withdrawal or watchdog
module decoder_rr_arbiter
  import decoder_pkg::*;
#(
  parameter int N_REQ       = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tmo_q, tmo_d;
  logic [MAX_REQ-1:0] req_ext;

`ifdef GRANT_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYC > 255) ? 32 : 8;
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT_CYC);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  // first set request at or after p, wrapping at N_REQ
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(p) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && r[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // widen req so indices at or above N_REQ read as never-requesting
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = bus.req;
  end

  // next-state, grant selection and release handling
  always_comb begin
    logic release_now;
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    tmo_d       = 1'b0;
    release_now = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_ext) begin
          idx_d   = rr_pick(req_ext, ptr_q);
          state_d = ST_GRANT;
`ifdef GRANT_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        release_now = bus.done || !req_ext[idx_q];
`ifdef GRANT_TIMEOUT_EN
        wdog_d = wdog_q + 1'b1;
        // a normal release wins, so the pulse only marks watchdog-forced drops
        if (!release_now && (wdog_d == WDOG_LIM)) begin
          release_now = 1'b1;
          tmo_d       = 1'b1;
        end
`endif
        if (release_now) begin
          state_d = ST_IDLE;
          ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, pointer and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
`ifdef GRANT_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign bus.gnt_valid = (state_q == ST_GRANT);
  assign bus.gnt_idx   = idx_q;

`ifdef GRANT_TIMEOUT_EN
  assign bus.gnt_timeout = tmo_q;
`else
  // no watchdog built; port kept so the interface does not change
  assign bus.gnt_timeout = 1'b0;
`endif

  decoder6_64 u_dec (
    .en (bus.gnt_valid),
    .a  (idx_q),
    .y  (bus.gnt_onehot)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter; expected grant indices are queued
// when requests are driven and popped when a grant appears.
module tb_decoder_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_rr_arbiter_if #(.N_REQ(64)) bus ();

  decoder_rr_arbiter #(.N_REQ(64), .TIMEOUT_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  function automatic logic [63:0] onehot_of(input int i);
    logic [63:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] bits_of(input int a, input int b, input int c);
    logic [63:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic wait_valid(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = '1;
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 64'h0 || bus.gnt_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b onehot=%h tmo=%b required 0/0/0",
               bus.gnt_valid, bus.gnt_onehot, bus.gnt_timeout);
    end
    rst_n = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    begin
      int e;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 6'(e) || bus.gnt_onehot !== onehot_of(e)) begin
        errors++;
        $display("FAIL reset_first_grant: valid=%b idx=%0d onehot=%h required 1/%0d/%h",
                 bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, e, onehot_of(e));
      end
    end
    bus.req = '0;
    pulse_done();
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 64'h0) begin
      errors++;
      $display("FAIL reset_release: valid=%b onehot=%h required 0/0", bus.gnt_valid, bus.gnt_onehot);
    end
  endtask

  task automatic test_rotation();
    bit ok;
    int cyc;
    int e;
    bus.req = bits_of(3, 10, 40);
    exp_q.push_back(3);
    exp_q.push_back(10);
    exp_q.push_back(40);
    exp_q.push_back(3);
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!ok || bus.gnt_idx !== 6'(e) || bus.gnt_onehot !== onehot_of(e) || (k > 0 && cyc != 1)) begin
        errors++;
        $display("FAIL rot_grant%0d: ok=%b idx=%0d onehot=%h wait=%0d required idx=%0d onehot=%h wait=1",
                 k, ok, bus.gnt_idx, bus.gnt_onehot, cyc, e, onehot_of(e));
      end
      pulse_done();
      checks++;
      if (bus.gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rot_bubble%0d: valid=%b required 0", k, bus.gnt_valid);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    int e;
    bus.req = bits_of(62, -1, -1);
    exp_q.push_back(62);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL wrap_62: ok=%b idx=%0d required %0d", ok, bus.gnt_idx, e);
    end
    bus.req = bits_of(63, 0, -1);
    exp_q.push_back(63);
    exp_q.push_back(0);
    pulse_done();
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!ok || bus.gnt_idx !== 6'(e) || bus.gnt_onehot !== onehot_of(e)) begin
        errors++;
        $display("FAIL wrap_grant%0d: ok=%b idx=%0d onehot=%h required idx=%0d onehot=%h",
                 k, ok, bus.gnt_idx, bus.gnt_onehot, e, onehot_of(e));
      end
      if (k == 1) bus.req = '0;
      pulse_done();
    end
  endtask

  task automatic test_withdraw();
    bit ok;
    int cyc;
    int e;
    bus.req = bits_of(5, -1, -1);
    exp_q.push_back(5);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL wd_grant: ok=%b idx=%0d required %0d", ok, bus.gnt_idx, e);
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_release: valid=%b tmo=%b required 0/0", bus.gnt_valid, bus.gnt_timeout);
    end
    bus.req = bits_of(4, 5, 6);
    exp_q.push_back(6);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc != 1 || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL wd_ptr: ok=%b wait=%0d idx=%0d required idx=%0d wait=1", ok, cyc, bus.gnt_idx, e);
    end
    bus.req = '0;
    pulse_done();
  endtask

  task automatic test_simul_release();
    bit ok;
    int cyc;
    int e;
    bus.req = bits_of(9, -1, -1);
    exp_q.push_back(9);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL sim_grant: ok=%b idx=%0d required %0d", ok, bus.gnt_idx, e);
    end
    bus.req = '0;
    pulse_done();
    checks++;
    if (bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL sim_release: valid=%b required 0", bus.gnt_valid);
    end
    bus.req = bits_of(8, 9, 10);
    exp_q.push_back(10);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc != 1 || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL sim_ptr: ok=%b wait=%0d idx=%0d required idx=%0d wait=1", ok, cyc, bus.gnt_idx, e);
    end
    bus.req = '0;
    pulse_done();
  endtask

`ifdef GRANT_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cyc;
    int e;
    int hi;
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = bits_of(2, 9, -1);
    exp_q.push_back(2);
    exp_q.push_back(9);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL tmo_grant: ok=%b idx=%0d required %0d", ok, bus.gnt_idx, e);
    end
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.gnt_valid) break;
      hi++;
    end
    checks++;
    if (hi != 4 || bus.gnt_timeout !== 1'b1 || bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_force: grant_cycles=%0d tmo=%b valid=%b required 4/1/0",
               hi, bus.gnt_timeout, bus.gnt_valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.gnt_timeout !== 1'b0 || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL tmo_next: tmo=%b valid=%b idx=%0d required 0/1/%0d",
               bus.gnt_timeout, bus.gnt_valid, bus.gnt_idx, e);
    end
    bus.req = '0;
    pulse_done();
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    int cyc;
    int e;
    int bad;
    bus.req = bits_of(11, -1, -1);
    exp_q.push_back(11);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.gnt_valid !== 1'b1 || bus.gnt_timeout !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bus.gnt_idx !== 6'(e) || bad != 0) begin
      errors++;
      $display("FAIL hold_long: ok=%b idx=%0d bad_cycles=%0d required idx=%0d bad_cycles=0",
               ok, bus.gnt_idx, bad, e);
    end
    bus.req = '0;
    pulse_done();
  endtask
`endif

  task automatic test_midgrant_reset();
    bit ok;
    int cyc;
    int e;
    bus.req = bits_of(20, -1, -1);
    exp_q.push_back(20);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bus.gnt_idx !== 6'(e)) begin
      errors++;
      $display("FAIL mr_grant: ok=%b idx=%0d required %0d", ok, bus.gnt_idx, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 64'h0) begin
      errors++;
      $display("FAIL mr_async: valid=%b onehot=%h required 0/0", bus.gnt_valid, bus.gnt_onehot);
    end
    bus.req = bits_of(7, 30, -1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(7);
    wait_valid(ok, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc != 1 || bus.gnt_idx !== 6'(e) || bus.gnt_onehot !== onehot_of(e)) begin
      errors++;
      $display("FAIL mr_after: ok=%b wait=%0d idx=%0d onehot=%h required idx=%0d",
               ok, cyc, bus.gnt_idx, bus.gnt_onehot, e);
    end
    bus.req = '0;
    pulse_done();
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_withdraw();
    test_simul_release();
`ifdef GRANT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_midgrant_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
